// File: rtl/cdc_hs_tx.sv
// -----------------------------------------------------------------------------
// cdc_hs_tx
//   Source-domain (clkA) end of a four-phase req/ack handshake that moves one
//   multi-bit word into another clock domain. A word taken from a valid/ready
//   source is held stable on tx_data while tx_req is raised. The returning
//   rx_ack is synchronised into clkA, and the handshake is sequenced through
//   req-high / ack-high / req-low / ack-low before the next word is taken.
//
// Ports
//   clkA       in   1           clock for this block
//   rstA       in   1           synchronous, active-high reset
//   src_valid  in   1           source offers src_data
//   src_data   in   DATA_WIDTH  word to transfer
//   src_ready  out  1           block accepts a word at the next edge
//   tx_req     out  1           request to the destination domain (registered)
//   tx_data    out  DATA_WIDTH  held word to the destination domain (registered)
//   rx_ack     in   1           acknowledge from the destination, async to clkA
//   done       out  1           one-cycle pulse when a handshake completes
//   busy       out  1           high whenever a transfer is in flight
// -----------------------------------------------------------------------------
module cdc_hs_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clkA,
  input  logic                  rstA,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  tx_req,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  rx_ack,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   req_next;
  logic                   done_next;
  logic                   load;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  // ---------------------------------------------------------------------------
  // rx_ack synchroniser: a plain flop chain with nothing between stages, so
  // the first stage is the only flop that can go metastable. ack_s is the
  // sole consumer of rx_ack anywhere in this block.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkA) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours; with = the chain would collapse.
    if (rstA) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], rx_ack};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // State register, together with the registered handshake outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkA) begin
    if (rstA) begin
      state   <= S_IDLE;
      tx_req  <= 1'b0;
      tx_data <= '0;
      done    <= 1'b0;
    end else begin
      state  <= state_next;
      tx_req <= req_next;
      done   <= done_next;
      // tx_data moves only on an accept, so it stays stable across the whole
      // req-high / ack-high window seen by the destination.
      if (load) begin
        tx_data <= src_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    state_next = state;
    req_next   = tx_req;
    done_next  = 1'b0;
    load       = 1'b0;

    case (state)
      S_IDLE: begin
        // src_ready already folds in !ack_s, so a stale acknowledge from a
        // previous transfer (or a reset mid-transfer) blocks the accept.
        if (src_valid && src_ready) begin
          load       = 1'b1;
          req_next   = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        // An ack that drops before ack_s ever rose is not seen here; we wait
        // for the rising level and nothing else.
        if (ack_s) begin
          req_next   = 1'b0;
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!ack_s) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registers only; src_ready never looks at src_valid,
  // so no combinational path exists from the source back to itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    src_ready = (state == S_IDLE) && !ack_s;
    busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// -----------------------------------------------------------------------------
// tb_cdc_hs_tx
//   Self-checking bench for cdc_hs_tx. Directed scenarios cover reset, a single
//   transfer, back-to-back words, a held-off source, reset mid-transfer and a
//   stuck acknowledge; a randomized phase then streams words with random gaps,
//   random ack delays and random back-to-back offers. The reference is
//   transaction level: an ordered list of offered words, the latency rule
//   "a synchronised level is acted on SYNC_STAGES+1 edges after it changes",
//   and a count of completed transfers.
// -----------------------------------------------------------------------------
module tb_cdc_hs_tx;

  localparam int DW = 8;
  localparam int S  = 2;
  localparam int N_RAND = 30;

  logic          clkA = 1'b0;
  logic          rstA;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          rx_ack;
  logic          done;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int done_wide = 0;
  int xfers    = 0;
  bit done_prev = 1'b0;

  cdc_hs_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(S)) dut (
    .clkA      (clkA),
    .rstA      (rstA),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .rx_ack    (rx_ack),
    .done      (done),
    .busy      (busy)
  );

  always #5 clkA = ~clkA;

  // Pulse monitor, sampled on the falling edge: counts done pulses and flags
  // any pulse that lasts longer than one cycle.
  always @(negedge clkA) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (done_prev) done_wide++;
    end
    done_prev = (done === 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge and settle just after it; inputs are driven and outputs
  // sampled here, well away from the next active edge.
  task automatic tick();
    @(posedge clkA);
    #1;
  endtask

  // Offer w until src_ready is seen, then let the accept edge pass. waited is
  // the number of edges spent waiting before the accept edge.
  task automatic accept_word(input logic [DW-1:0] w, input bit hold, output int waited);
    int n;
    n = 0;
    src_valid = 1'b1;
    src_data  = w;
    while (src_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("ready_seen", src_ready, 1);
    waited = n;
    tick();
    if (!hold) src_valid = 1'b0;
  endtask

  // Play the destination for one transfer of w that was just accepted:
  // raise rx_ack d1 edges after req rose, drop it d2 edges after req fell.
  // Returns in the cycle where done is high.
  task automatic respond(input logic [DW-1:0] w, input int d1, input int d2);
    int n;
    check("req_after_accept", tx_req, 1);
    check("data_captured", tx_data, w);
    check("busy_in_req", busy, 1);
    check("ready_low_busy", src_ready, 0);
    repeat (d1) begin
      tick();
      check("req_hold", tx_req, 1);
      check("data_hold_req", tx_data, w);
      check("no_done_req", done, 0);
    end
    rx_ack = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (tx_req === 1'b1 && n < 20);
    check("req_fall_latency", n, S + 1);
    check("data_hold_ack", tx_data, w);
    check("busy_in_release", busy, 1);
    repeat (d2) begin
      tick();
      check("req_low_release", tx_req, 0);
      check("no_done_release", done, 0);
      check("data_hold_release", tx_data, w);
    end
    rx_ack = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 20);
    check("done_latency", n, S + 1);
    check("idle_on_done", busy, 0);
    check("data_after_done", tx_data, w);
    xfers++;
  endtask

  initial begin
    int w;
    int c0;
    logic [DW-1:0] words [N_RAND];
    bit keep;
    bit keep_next;

    // ---------------- reset with a word on offer ----------------
    rstA      = 1'b1;
    src_valid = 1'b1;
    src_data  = 8'hA5;
    rx_ack    = 1'b0;
    repeat (3) begin
      tick();
      check("rst_req", tx_req, 0);
      check("rst_data", tx_data, 8'h00);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
    end
    rstA      = 1'b0;
    src_valid = 1'b0;
    tick();
    check("ready_after_rst", src_ready, 1);
    check("no_accept_in_rst", tx_req, 0);

    // ---------------- single transfer ----------------
    c0 = done_cnt;
    accept_word(8'h3C, 1'b0, w);
    check("single_wait", w, 0);
    respond(8'h3C, 4, 4);
    tick();
    check("single_done_count", done_cnt - c0, 1);
    check("single_done_drop", done, 0);
    check("single_ready", src_ready, 1);

    // ---------------- back-to-back 01, 02, 03 ----------------
    c0 = done_cnt;
    accept_word(8'h01, 1'b1, w);
    src_data = 8'h02;
    respond(8'h01, 1, 2);
    check("b2b_ready_on_done", src_ready, 1);
    accept_word(8'h02, 1'b1, w);
    check("b2b_accept_on_done_2", w, 0);
    src_data = 8'h03;
    respond(8'h02, 0, 0);
    accept_word(8'h03, 1'b0, w);
    check("b2b_accept_on_done_3", w, 0);
    respond(8'h03, 3, 1);
    tick();
    check("b2b_done_count", done_cnt - c0, 3);

    // ---------------- held-off source ----------------
    accept_word(8'h5A, 1'b1, w);
    src_data = 8'hFF;
    respond(8'h5A, 3, 3);
    accept_word(8'hFF, 1'b0, w);
    check("held_accept_after_done", w, 0);
    respond(8'hFF, 2, 2);
    tick();

    // ---------------- reset in the middle of a transfer ----------------
    accept_word(8'h77, 1'b0, w);
    tick();
    rx_ack = 1'b1;
    tick();
    rstA = 1'b1;
    tick();
    check("midrst_req", tx_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", tx_data, 8'h00);
    check("midrst_done", done, 0);
    rstA = 1'b0;
    // The synchroniser restarts from zero, so the held ack reaches ack_s
    // SYNC_STAGES edges after release and blocks the source from then on.
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= S) check("midrst_ready_blocked", src_ready, 0);
      check("midrst_idle", busy, 0);
    end
    rx_ack = 1'b0;
    for (int j = 1; j <= S + 1; j++) begin
      tick();
      if (j < S) check("midrst_ready_still_low", src_ready, 0);
      if (j == S + 1) check("midrst_ready_back", src_ready, 1);
    end

    // ---------------- stuck acknowledge while idle ----------------
    rx_ack = 1'b1;
    repeat (S) tick();
    src_valid = 1'b1;
    src_data  = 8'hC3;
    repeat (6) begin
      tick();
      check("stuck_ready", src_ready, 0);
      check("stuck_busy", busy, 0);
      check("stuck_req", tx_req, 0);
    end
    rx_ack = 1'b0;
    accept_word(8'hC3, 1'b0, w);
    check("stuck_release_ready", (w <= S + 1), 1);
    respond(8'hC3, 1, 1);
    tick();

    // ---------------- randomized stream ----------------
    foreach (words[k]) words[k] = DW'($urandom);
    keep = 1'b0;
    for (int i = 0; i < N_RAND; i++) begin
      if (!keep) repeat ($urandom_range(0, 3)) tick();
      keep_next = (i < N_RAND - 1) && ($urandom_range(0, 1) == 1);
      accept_word(words[i], keep_next, w);
      if (keep) check("rand_accept_on_done", w, 0);
      if (keep_next) src_data = words[i + 1];
      respond(words[i], $urandom_range(0, 5), $urandom_range(0, 5));
      keep = keep_next;
    end
    tick();
    check("done_drop_final", done, 0);
    check("done_total", done_cnt, xfers);
    check("done_one_cycle", done_wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
